// File: rtl/dcache_dm.sv
// Direct-mapped write-through / no-write-allocate data cache with line refill over a req/ack word bus.
// Define DCACHE_PERF_EN to build the hit/miss counters; otherwise perf_hit/perf_miss are tied to 0.
module dcache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic                  Mem_DcacheSign,
  input  logic [31:0]           Mem_DcacheWdata,
  output logic [31:0]           Dcache_DataRd,
  output logic                  Dcache_Stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
);
  localparam int WI_W  = $clog2(LINE_WORDS);
  localparam int SI_W  = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - WI_W - SI_W;
  localparam int DEPTH = SETS * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t state, state_next;

  logic [31:0]      data_arr [DEPTH];
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [SETS-1:0]  valid;

  logic [1:0]            off;
  logic [WI_W-1:0]       word_idx;
  logic [SI_W-1:0]       set_idx;
  logic [TAG_W-1:0]      tag;
  logic [WI_W-1:0]       rf_word;
  logic [SI_W-1:0]       rf_set;
  logic [TAG_W-1:0]      rf_tag;
  logic                  active, hit, rf_last;
  logic [31:0]           hit_word;
  logic                  done, done_rd, done_match;
  logic [ADDR_WIDTH-1:0] done_addr;
  logic                  start_refill, start_write;
  logic [31:0]           store_lanes;
  logic [3:0]            store_strb;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] width,
                                               input logic [1:0] ofs, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ofs, 3'b000} +: 8];
    h = w[{ofs[1], 4'b0000} +: 16];
    case (width)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      2'b10:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] width, input logic [1:0] ofs);
    case (width)
      2'b00:   return 4'b0001 << ofs;
      2'b01:   return 4'b0011 << {ofs[1], 1'b0};
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [1:0] ofs,
                                            input logic [31:0] w);
    case (width)
      2'b00:   return {24'h0, w[7:0]} << {ofs, 3'b000};
      2'b01:   return {16'h0, w[15:0]} << {ofs[1], 4'b0000};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] upd,
                                              input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (upd & mask);
  endfunction

  assign off      = Mem_DcacheAddr[1:0];
  assign word_idx = Mem_DcacheAddr[2 +: WI_W];
  assign set_idx  = Mem_DcacheAddr[2 + WI_W +: SI_W];
  assign tag      = Mem_DcacheAddr[ADDR_WIDTH-1 -: TAG_W];
  assign rf_word  = mem_addr[2 +: WI_W];
  assign rf_set   = mem_addr[2 + WI_W +: SI_W];
  assign rf_tag   = mem_addr[ADDR_WIDTH-1 -: TAG_W];
  assign rf_last  = &rf_word;

  assign active      = Mem_DcacheEN && (Mem_DcacheWidth != 2'b11);
  assign hit         = valid[set_idx] && (tag_arr[set_idx] == tag);
  assign hit_word    = data_arr[{set_idx, word_idx}];
  assign done_match  = done && (Mem_DcacheAddr == done_addr) && (Mem_DcacheRd == done_rd);
  assign store_lanes = lane_data(Mem_DcacheWidth, off, Mem_DcacheWdata);
  assign store_strb  = lane_strb(Mem_DcacheWidth, off);

  always_comb begin
    state_next    = state;
    Dcache_Stall  = 1'b0;
    Dcache_DataRd = 32'h0;
    start_refill  = 1'b0;
    start_write   = 1'b0;
    case (state)
      IDLE: begin
        if (active && !done_match) begin
          if (Mem_DcacheRd) begin
            if (hit) begin
              Dcache_DataRd = load_extract(hit_word, Mem_DcacheWidth, off, Mem_DcacheSign);
            end else begin
              Dcache_Stall = 1'b1;
              start_refill = 1'b1;
              state_next   = REFILL;
            end
          end else begin
            Dcache_Stall = 1'b1;
            start_write  = 1'b1;
            state_next   = WRITE;
          end
        end
      end
      REFILL: begin
        Dcache_Stall = 1'b1;
        if (mem_ack && rf_last) state_next = IDLE;
      end
      WRITE: begin
        Dcache_Stall = 1'b1;
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus control and valid bits; the line is invalidated before refill so an abandoned fill never hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      valid     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_refill) begin
            mem_req          <= 1'b1;
            mem_we           <= 1'b0;
            mem_addr         <= {tag, set_idx, {WI_W{1'b0}}, 2'b00};
            valid[set_idx]   <= 1'b0;
          end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= store_lanes;
            mem_wstrb <= store_strb;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_addr[2 +: WI_W] <= rf_word + 1'b1;
            if (rf_last) begin
              mem_req       <= 1'b0;
              valid[rf_set] <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays and the completed-store key carry no reset.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_arr[{rf_set, rf_word}] <= mem_rdata;
      if (rf_last) tag_arr[rf_set] <= rf_tag;
    end
    if (start_write && hit) begin
      data_arr[{set_idx, word_idx}] <= merge_bytes(hit_word, store_lanes, store_strb);
    end
    if (state == WRITE && mem_ack) begin
      done_addr <= Mem_DcacheAddr;
      done_rd   <= Mem_DcacheRd;
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
  logic        ev_hit, ev_miss;
  assign ev_hit  = (state == IDLE) && active && !done_match && hit;
  assign ev_miss = start_refill || (start_write && !hit);
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (ev_hit)  hit_cnt  <= hit_cnt + 32'h1;
      if (ev_miss) miss_cnt <= miss_cnt + 32'h1;
    end
  end
  assign perf_hit  = hit_cnt;
  assign perf_miss = miss_cnt;
`else
  assign perf_hit  = 32'h0;
  assign perf_miss = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed accesses, a bus responder acking every second cycle.
module tb_dcache_dm;
  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheSign;
  logic [1:0]  Mem_DcacheWidth;
  logic [31:0] Mem_DcacheAddr, Mem_DcacheWdata;
  logic [31:0] Dcache_DataRd;
  logic        Dcache_Stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] perf_hit, perf_miss;

  dcache_dm #(.ADDR_WIDTH(32), .LINE_WORDS(4), .SETS(64)) dut (
    .clk(clk), .rst(rst),
    .Mem_DcacheEN(Mem_DcacheEN), .Mem_DcacheRd(Mem_DcacheRd), .Mem_DcacheWidth(Mem_DcacheWidth),
    .Mem_DcacheAddr(Mem_DcacheAddr), .Mem_DcacheSign(Mem_DcacheSign), .Mem_DcacheWdata(Mem_DcacheWdata),
    .Dcache_DataRd(Dcache_DataRd), .Dcache_Stall(Dcache_Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct { logic is_load; logic [31:0] data; int stalls; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  exp_t  exp_q[$];
  string name_q[$];
  wr_t   wr_q[$];
  logic [31:0] mem_model [logic [31:0]];
  bit auto_en = 1'b1;
  int gap = 0;
  int rd_cnt = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Bus responder: acks every second cycle of a request; checks writes against the write queue.
  always @(negedge clk) begin
    wr_t w;
    logic [31:0] m;
    if (auto_en) begin
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (gap == 1) begin
          gap = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            if (wr_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_write: addr %h data %h strb %b, none expected", mem_addr, mem_wdata, mem_wstrb);
            end else begin
              w = wr_q.pop_front();
              check("wr_addr", mem_addr, w.addr);
              check("wr_data", mem_wdata, w.data);
              check("wr_strb", 32'(mem_wstrb), 32'(w.strb));
            end
            m = model_rd(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_wstrb[i]) m[8*i +: 8] = mem_wdata[8*i +: 8];
            mem_model[mem_addr] = m;
          end else begin
            mem_rdata = model_rd(mem_addr);
            rd_cnt++;
          end
        end else begin
          gap++;
        end
      end else begin
        gap = 0;
      end
    end
  end

  // Monitor: counts stall cycles of the live request and scores it when it completes.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (rst || !(Mem_DcacheEN && Mem_DcacheWidth != 2'b11)) begin
      stall_cnt = 0;
    end else if (Dcache_Stall) begin
      stall_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: addr %h data %h, none expected", Mem_DcacheAddr, Dcache_DataRd);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.is_load) check({nm, "_data"}, Dcache_DataRd, e.data);
        check({nm, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
      end
      stall_cnt = 0;
    end
  end

  task automatic issue(input string name, input logic rd, input logic [1:0] width,
                       input logic [31:0] addr, input logic sgn, input logic [31:0] wd,
                       input logic [31:0] exp_data, input int exp_stalls);
    exp_t e;
    int n;
    e.is_load = rd;
    e.data    = exp_data;
    e.stalls  = exp_stalls;
    exp_q.push_back(e);
    name_q.push_back(name);
    Mem_DcacheRd    = rd;
    Mem_DcacheWidth = width;
    Mem_DcacheAddr  = addr;
    Mem_DcacheSign  = sgn;
    Mem_DcacheWdata = wd;
    Mem_DcacheEN    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Dcache_Stall && n < 200);
    if (Dcache_Stall) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required completion", name, n);
    end
    @(posedge clk); #1;
    Mem_DcacheEN = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic store(input string name, input logic [1:0] width, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] bus_addr,
                       input logic [31:0] bus_data, input logic [3:0] bus_strb);
    wr_t w;
    w.addr = bus_addr;
    w.data = bus_data;
    w.strb = bus_strb;
    wr_q.push_back(w);
    issue(name, 1'b0, width, addr, 1'b0, wd, 32'h0, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_model[32'h100] = 32'h11111111;
    mem_model[32'h104] = 32'h22222222;
    mem_model[32'h108] = 32'h33333333;
    mem_model[32'h10C] = 32'h44444444;
    mem_model[32'h500] = 32'h55555555;
    mem_model[32'h800] = 32'h88888888;
    mem_model[32'h804] = 32'h12345678;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    Mem_DcacheEN = 1'b0; Mem_DcacheRd = 1'b0; Mem_DcacheWidth = 2'b10;
    Mem_DcacheAddr = 32'h0; Mem_DcacheSign = 1'b0; Mem_DcacheWdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_stall", 32'(Dcache_Stall), 32'h0);
    check("rst_perf_hit", perf_hit, 32'h0);
    check("rst_perf_miss", perf_miss, 32'h0);

    // Cold miss: 4 acks two cycles apart plus the detect cycle.
    issue("ld_miss_100", 1'b1, 2'b10, 32'h100, 1'b0, 32'h0, 32'h11111111, 9);
    check("refill_reads", 32'(rd_cnt), 32'd4);
    issue("ld_hit_10c", 1'b1, 2'b10, 32'h10C, 1'b0, 32'h0, 32'h44444444, 0);
    issue("ld_hit_104", 1'b1, 2'b10, 32'h104, 1'b0, 32'h0, 32'h22222222, 0);
    check("hit_no_reads", 32'(rd_cnt), 32'd4);

    // No-op width and disabled access.
    Mem_DcacheRd = 1'b1; Mem_DcacheAddr = 32'h100; Mem_DcacheWidth = 2'b11; Mem_DcacheEN = 1'b1;
    #1;
    check("noop_stall", 32'(Dcache_Stall), 32'h0);
    check("noop_data", Dcache_DataRd, 32'h0);
    @(posedge clk); #1;
    check("noop_no_req", 32'(mem_req), 32'h0);
    Mem_DcacheWidth = 2'b10; Mem_DcacheEN = 1'b0;
    #1;
    check("en0_data", Dcache_DataRd, 32'h0);
    check("en0_stall", 32'(Dcache_Stall), 32'h0);
    @(posedge clk); #1;

    store("st_w_100", 2'b10, 32'h100, 32'h000080F0, 32'h100, 32'h000080F0, 4'b1111);
    issue("ld_sb_100", 1'b1, 2'b00, 32'h100, 1'b1, 32'h0, 32'hFFFFFFF0, 0);
    issue("ld_ub_100", 1'b1, 2'b00, 32'h100, 1'b0, 32'h0, 32'h000000F0, 0);
    issue("ld_sh_100", 1'b1, 2'b01, 32'h100, 1'b1, 32'h0, 32'hFFFF80F0, 0);
    issue("ld_uh_102", 1'b1, 2'b01, 32'h102, 1'b0, 32'h0, 32'h00000000, 0);
    issue("ld_sb_101", 1'b1, 2'b00, 32'h101, 1'b1, 32'h0, 32'hFFFFFF80, 0);
    issue("ld_uh_101", 1'b1, 2'b01, 32'h101, 1'b0, 32'h0, 32'h000080F0, 0);

    store("st_b_101", 2'b00, 32'h101, 32'h000000AB, 32'h100, 32'h0000AB00, 4'b0010);
    issue("ld_w_100", 1'b1, 2'b10, 32'h100, 1'b0, 32'h0, 32'h0000ABF0, 0);
    issue("ld_w_103", 1'b1, 2'b10, 32'h103, 1'b0, 32'h0, 32'h0000ABF0, 0);

    // Store miss does not allocate.
    store("st_w_2000", 2'b10, 32'h2000, 32'hDEADBEEF, 32'h2000, 32'hDEADBEEF, 4'b1111);
    issue("ld_miss_2000", 1'b1, 2'b10, 32'h2000, 1'b0, 32'h0, 32'hDEADBEEF, 9);
    check("reads_after_2000", 32'(rd_cnt), 32'd8);

    // Same set, different tag: each swap refills.
    issue("ld_conf_500", 1'b1, 2'b10, 32'h500, 1'b0, 32'h0, 32'h55555555, 9);
    issue("ld_conf_100", 1'b1, 2'b10, 32'h100, 1'b0, 32'h0, 32'h0000ABF0, 9);
    store("st_h_106", 2'b01, 32'h106, 32'h0000BEEF, 32'h104, 32'hBEEF0000, 4'b1100);
    issue("ld_w_104", 1'b1, 2'b10, 32'h104, 1'b0, 32'h0, 32'hBEEF2222, 0);
    issue("ld_conf_500b", 1'b1, 2'b10, 32'h500, 1'b0, 32'h0, 32'h55555555, 9);

    // Reset in the middle of a refill, then a stray ack.
    auto_en = 1'b0;
    mem_ack = 1'b0;
    Mem_DcacheRd = 1'b1; Mem_DcacheWidth = 2'b10; Mem_DcacheAddr = 32'h800; Mem_DcacheEN = 1'b1;
    @(posedge clk); #1;
    check("rf_req", 32'(mem_req), 32'h1);
    check("rf_we", 32'(mem_we), 32'h0);
    check("rf_addr0", mem_addr, 32'h800);
    mem_rdata = 32'hAAAA0000; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rf_addr1", mem_addr, 32'h804);
    mem_rdata = 32'hAAAA0001; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rf_req_mid", 32'(mem_req), 32'h1);
    rst = 1'b1; Mem_DcacheEN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req", 32'(mem_req), 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_perf_hit", perf_hit, 32'h0);
    check("abort_perf_miss", perf_miss, 32'h0);
    mem_rdata = 32'hAAAA0002; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'h0);
    check("late_ack_stall", 32'(Dcache_Stall), 32'h0);
    gap = 0;
    auto_en = 1'b1;
    @(posedge clk); #1;

    issue("ld_after_abort_800", 1'b1, 2'b10, 32'h800, 1'b0, 32'h0, 32'h88888888, 9);
    issue("ld_hit_804", 1'b1, 2'b10, 32'h804, 1'b0, 32'h0, 32'h12345678, 0);
    issue("ld_after_rst_100", 1'b1, 2'b10, 32'h100, 1'b0, 32'h0, 32'h0000ABF0, 9);

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
